// File: rtl/mem_2p_bytewe.sv
// Simple-dual-port RAM: byte-enabled write port A, synchronous read port B,
// optional output register, selectable read-during-write and a zero-fill engine.
module mem_2p_bytewe #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 14,
    parameter int OUT_REG        = 0,
    parameter int RDW_NEW        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_en,
    input  logic [DWIDTH/8-1:0]    a_we,
    input  logic [AWIDTH-1:0]      a_addr,
    input  logic [DWIDTH-1:0]      a_din,
    input  logic                   b_en,
    input  logic [AWIDTH-1:0]      b_addr,
    output logic [DWIDTH-1:0]      b_dout,
    output logic                   b_valid,
    input  logic                   clear_req,
    output logic                   busy
);
    localparam int NB    = DWIDTH / 8;
    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic                pend_q;
    logic [DWIDTH-1:0]   mem [DEPTH];
    logic [DWIDTH-1:0]   rd_data;
    logic [DWIDTH-1:0]   rd_q;
    logic                vld_q;
    logic                rd_acc;

    assign busy   = (state_q == CLEAR);
    assign rd_acc = b_en & ~busy;

    // pend_q marks the first cycle after reset release, which kicks off the auto-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req || (pend_q && CLEAR_ON_RESET != 0)) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Array has no reset; the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (a_en) begin
            for (int i = 0; i < NB; i++)
                if (a_we[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
        end
    end

    // Same-address bypass: only lanes being written this cycle see new data
    always_comb begin
        rd_data = mem[b_addr];
        if (RDW_NEW != 0 && a_en && !busy && a_addr == b_addr) begin
            for (int i = 0; i < NB; i++)
                if (a_we[i]) rd_data[8*i +: 8] = a_din[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= rd_acc;
            if (rd_acc) rd_q <= rd_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DWIDTH-1:0] rd2_q;
            logic              vld2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd2_q  <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    vld2_q <= vld_q;
                    if (vld_q) rd2_q <= rd_q;
                end
            end
            assign b_dout  = rd2_q;
            assign b_valid = vld2_q;
        end else begin : g_noreg
            assign b_dout  = rd_q;
            assign b_valid = vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_mem_2p_bytewe.sv
// Drives two RAM variants in lockstep (latency-1/old-data and latency-2/new-data)
// and scores their read streams against a bench-side memory model.
module tb_mem_2p_bytewe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0;
    logic [3:0]  a_we = '0;
    logic [3:0]  a_addr = '0;
    logic [31:0] a_din = '0;
    logic        b_en = 1'b0;
    logic [3:0]  b_addr = '0;
    logic        clear_req = 1'b0;
    logic [31:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_seen = 1'b1;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        int          due;
    } ent_t;
    ent_t        sb[$];
    int          rp[2];
    logic [31:0] last[2];
    logic [31:0] mdl[16];

    always #5 clk = ~clk;

    mem_2p_bytewe #(.DWIDTH(32), .AWIDTH(4), .OUT_REG(0), .RDW_NEW(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .b_en(b_en), .b_addr(b_addr), .b_dout(dout0), .b_valid(vld0),
        .clear_req(clear_req), .busy(busy0));

    mem_2p_bytewe #(.DWIDTH(32), .AWIDTH(4), .OUT_REG(1), .RDW_NEW(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .b_en(b_en), .b_addr(b_addr), .b_dout(dout1), .b_valid(vld1),
        .clear_req(clear_req), .busy(busy1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Read monitor: each DUT consumes the shared scoreboard at its own latency
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int d = 0; d < 2; d++) begin
                logic        v;
                logic [31:0] o, e;
                v = (d == 0) ? vld0 : vld1;
                o = (d == 0) ? dout0 : dout1;
                if (rst_seen) begin
                    chk(d ? "rst_vld1" : "rst_vld0", v, 1'b0);
                    chk(d ? "rst_dout1" : "rst_dout0", o, 32'h0);
                    last[d] = '0;
                end else if (rp[d] < sb.size() && sb[rp[d]].due + d == cyc) begin
                    e = (d == 0) ? sb[rp[d]].e0 : sb[rp[d]].e1;
                    chk(d ? "rd_vld1" : "rd_vld0", v, 1'b1);
                    chk(d ? "rd_data1" : "rd_data0", o, e);
                    last[d] = e;
                    rp[d]++;
                end else begin
                    chk(d ? "idle_vld1" : "idle_vld0", v, 1'b0);
                    chk(d ? "hold_dout1" : "hold_dout0", o, last[d]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; bsy tells the model whether the DUT is clearing
    task automatic op(input bit aen, input logic [3:0] we, input logic [3:0] aa,
                      input logic [31:0] ad, input bit ben, input logic [3:0] ba, input bit bsy);
        logic [31:0] old, mrg;
        a_en = aen; a_we = we; a_addr = aa; a_din = ad; b_en = ben; b_addr = ba;
        if (ben && !bsy) begin
            old = mdl[ba];
            mrg = old;
            if (aen && aa == ba)
                for (int i = 0; i < 4; i++) if (we[i]) mrg[8*i +: 8] = ad[8*i +: 8];
            sb.push_back('{old, mrg, cyc + 1});
        end
        if (aen && !bsy)
            for (int i = 0; i < 4; i++) if (we[i]) mdl[aa][8*i +: 8] = ad[8*i +: 8];
        tick();
        a_en = 1'b0; a_we = '0; b_en = 1'b0;
    endtask

    task automatic wait_clear(input int n);
        for (int i = 0; i < n; i++) begin
            chk("busy_hi", {busy1, busy0}, 2'b11);
            tick();
        end
        chk("busy_lo", {busy1, busy0}, 2'b00);
        for (int i = 0; i < 16; i++) mdl[i] = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        rp[0] = 0; rp[1] = 0; last[0] = '0; last[1] = '0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        tick(); tick(); tick();
        chk("rst_busy", {busy1, busy0}, 2'b00);

        // Power-up auto clear
        rst = 1'b0;
        tick();
        wait_clear(16);

        // Preload all-ones, reset, auto clear must zero everything
        for (int a = 0; a < 16; a++) op(1, 4'hF, 4'(a), 32'hFFFF_FFFF, 0, 0, 0);
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy2", {busy1, busy0}, 2'b00);
        rst = 1'b0;
        tick();
        wait_clear(16);
        for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 4'(a), 0);
        drain();

        // Byte-enable merge
        op(1, 4'b1111, 4'd5, 32'hAABB_CCDD, 0, 0, 0);
        op(1, 4'b0101, 4'd5, 32'h1122_3344, 0, 0, 0);
        op(0, 0, 0, 0, 1, 4'd5, 0);
        drain();
        chk("model_be", mdl[5], 32'hAA22_CC44);

        // Same-address read-during-write, then plain read-back
        op(1, 4'b0011, 4'd3, 32'hDEAD_BEEF, 1, 4'd3, 0);
        op(0, 0, 0, 0, 1, 4'd3, 0);
        drain();

        // Streaming reads with concurrent writes to other addresses
        for (int a = 0; a < 8; a++) op(1, 4'hF, 4'(a), 32'h5A5A_0000 ^ (a * 32'h0101_0101), 0, 0, 0);
        for (int a = 0; a < 8; a++) op(1, 4'hF, 4'(a + 8), 32'hC0DE_0000 + a, 1, 4'(a), 0);
        drain();

        // clear_req: its own edge still does normal access; writes/reads/re-requests dropped while busy
        clear_req = 1'b1;
        op(1, 4'hF, 4'd9, 32'hCAFE_F00D, 1, 4'd4, 0);
        clear_req = 1'b0;
        chk("busy_start", {busy1, busy0}, 2'b11);
        clear_req = 1'b1;
        op(1, 4'hF, 4'd2, 32'h1234_5678, 1, 4'd2, 1);
        clear_req = 1'b0;
        wait_clear(15);
        op(0, 0, 0, 0, 1, 4'd2, 0);
        op(0, 0, 0, 0, 1, 4'd9, 0);
        op(0, 0, 0, 0, 1, 4'd4, 0);
        drain();

        // Reset six cycles into a clear restarts a full clear
        for (int a = 0; a < 16; a++) op(1, 4'hF, 4'(a), 32'h0100_0000 + a + 1, 0, 0, 0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("busy_mid", {busy1, busy0}, 2'b11);
        rst = 1'b1;
        tick(); tick();
        chk("busy_in_rst", {busy1, busy0}, 2'b00);
        rst = 1'b0;
        tick();
        wait_clear(16);
        for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 4'(a), 0);
        drain();

        chk("sb_done0", rp[0], sb.size());
        chk("sb_done1", rp[1], sb.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_2p_bytewe.md
# mem_2p_bytewe

Parametrised simple-dual-port synchronous RAM: port A is a byte-enabled write port and port B a synchronous read port. It replaces the fixed 32x16K instruction/data memories in the CPU and the memory-mapped I/O path. Compared with those memories it adds:
- configurable data width and depth;
- an optional output register;
- selectable read-during-write behaviour;
- a hardware clear engine that zero-fills the array after reset or on request, with a busy flag.

## Interface
Parameters:
- DWIDTH, 32, data width in bits; must be a multiple of 8. NB = DWIDTH/8 byte lanes.
- AWIDTH, 14, address width; DEPTH = 2**AWIDTH words.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- RDW_NEW, 0, same-address read-during-write: 0 returns old data, 1 returns newly written bytes merged with old.
- CLEAR_ON_RESET, 1, 1 starts a full zero-fill when rst deasserts.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_en  in  1  port A enable.
- a_we  in  NB  byte write enables; lane i covers a_din[8i+7:8i].
- a_addr  in  AWIDTH  write word address.
- a_din  in  DWIDTH  write data.
- b_en  in  1  port B read request.
- b_addr  in  AWIDTH  read word address.
- b_dout  out  DWIDTH  read data.
- b_valid  out  1  b_dout holds data for an accepted read.
- clear_req  in  1  single-cycle pulse that starts a zero-fill.
- busy  out  1  clear engine active.

## Operation
- Write: on a posedge with a_en=1, busy=0 and a_we[i]=1, byte i of mem[a_addr] takes a_din byte i. Lanes with a_we[i]=0 are unchanged. a_en=0 or a_we=0 writes nothing.
- Read: a read is accepted on a posedge with b_en=1 and busy=0; its data appears after the read latency.
- Read during busy: b_en is ignored and no b_valid pulse is produced for it.
- b_dout holds its last value when no read completes.
- Read-during-write, same cycle and same address:
  - RDW_NEW=0: read returns the pre-write contents.
  - RDW_NEW=1: each lane i returns a_din byte i if a_we[i]=1, otherwise the old byte.
  - Different addresses never interact.
- Clear engine FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_req=1, or on the first cycle after rst deasserts if CLEAR_ON_RESET=1.
  - In CLEAR, a counter cnt starts at 0. Each cycle writes mem[cnt]=0, then cnt increments.
  - CLEAR -> IDLE after writing DEPTH-1; cnt wraps to 0.
  - Port A writes are dropped for the whole CLEAR state.
  - clear_req while in CLEAR is ignored; the clear does not restart.
- Reset: rst=1 forces IDLE, cnt=0, b_valid=0 and b_dout=0, and empties the output pipeline. Array contents are not reset by rst itself.
- Reset mid-clear: rst aborts the clear. If CLEAR_ON_RESET=1, a new clear starts from address 0 after rst deasserts. If CLEAR_ON_RESET=0, the array is left partially cleared and busy=0.

## Timing
- Reset values: b_dout=0, b_valid=0, busy=0 while rst=1.
- After rst falls, busy=1 from the next posedge if CLEAR_ON_RESET=1.
- Clear duration: busy is high for exactly DEPTH cycles. The first posedge with busy=0 accepts reads and writes.
- clear_req sampled at edge T gives busy=1 after T. Edge T itself still performs any normal access.
- Read latency, OUT_REG=0: read accepted at edge T gives b_dout and b_valid=1 after T, valid until edge T+1.
- Read latency, OUT_REG=1: data appears after edge T+1.
- b_valid is a one-cycle pulse per accepted read. Back-to-back reads every cycle give continuous valid data with no bubbles.
- Write visibility: a write at edge T is visible to a read accepted at T+1 or later. A read accepted at T itself follows RDW_NEW.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset clear, DWIDTH=32, AWIDTH=4, CLEAR_ON_RESET=1: preload 0xFFFFFFFF at all addresses, pulse rst -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 all return 0x00000000 with b_valid asserted one cycle after each read.
- Byte enables: write 0xAABBCCDD to address 5 with a_we=4'b1111, then 0x11223344 with a_we=4'b0101 -> read of address 5 returns 0xAA22CC44.
- Read-during-write at address 3 (old value 0x00000000), writing 0xDEADBEEF with a_we=4'b0011 in the same cycle -> RDW_NEW=0 returns 0x00000000; RDW_NEW=1 returns 0x0000BEEF; the next read returns 0x0000BEEF in both modes.
- OUT_REG=1 streaming reads of addresses 0..7 on consecutive cycles -> b_valid high for 8 consecutive cycles starting 2 cycles after the first request, data in address order.
- Clear interaction: pulse clear_req; during busy issue a write of 0x12345678 to address 2 and a read -> write dropped, no b_valid; after busy falls, address 2 reads 0.
- Reset mid-clear: assert rst 6 cycles into a clear -> busy=0 during rst; after rst falls busy stays high a full 16 cycles, and every address reads 0 afterwards.
